lcd_driver: RTL and testbench

Consumer end of the score-to-LCD interface. Accepts a 32-character frame (`ASCII`) on an `UpdateLCD` trigger and writes it to the 16x2 HD44780 character LCD over the 8-bit parallel bus. Asserts `LCDBusy` while powering up or writing a frame. Sits between the score/formatting logic and the board LCD pins.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_xfer.sv | 94 +++++++++
 rtl/lcd_driver.sv | 158 +++++++++++++++
 tb/tb_lcd_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Command codes, state encodings and the power-up command table for the HD44780 driver.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  typedef enum logic [1:0] {ST_PWR, ST_INIT, ST_IDLE, ST_FRAME} lcd_state_t;
  typedef enum logic [1:0] {XF_IDLE, XF_SETUP, XF_PULSE, XF_HOLD} xfer_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// One-byte HD44780 write: SETUP (2 clk), EN pulse, then a hold that is longer after a clear.
// o_done is high in the last hold cycle; a start in that cycle chains the next byte with no gap.
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYCLES  = 16,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_rs,
  output logic [7:0] o_data,
  output logic       o_en
);

  xfer_state_t r_state;
  logic [31:0] r_cnt;
  logic        r_done;
  logic        r_en;
  logic        r_rs;
  logic [7:0]  r_data;
  logic [31:0] w_hold;

  assign w_hold = (!r_rs && (r_data == LCD_CLEAR)) ? CLEAR_WAIT : CMD_WAIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= XF_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        XF_IDLE: begin
          if (i_start) begin
            r_state <= XF_SETUP;
            r_cnt   <= '0;
            r_rs    <= i_rs;
            r_data  <= i_data;
          end
        end
        XF_SETUP: begin
          if (r_cnt == 32'd1) begin
            r_state <= XF_PULSE;
            r_cnt   <= '0;
            r_en    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        XF_PULSE: begin
          if (r_cnt == EN_CYCLES - 1) begin
            r_state <= XF_HOLD;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_done  <= (w_hold == 32'd1);
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          // RS/DATA stay put through the hold and after it, until the next start.
          if (r_cnt == w_hold - 32'd1) begin
            r_cnt <= '0;
            if (i_start) begin
              r_state <= XF_SETUP;
              r_rs    <= i_rs;
              r_data  <= i_data;
            end else begin
              r_state <= XF_IDLE;
            end
          end else begin
            r_cnt  <= r_cnt + 32'd1;
            r_done <= (r_cnt == w_hold - 32'd2);
          end
        end
      endcase
    end
  end

  assign o_done = r_done;
  assign o_rs   = r_rs;
  assign o_data = r_data;
  assign o_en   = r_en;

endmodule

// File: rtl/lcd_driver.sv
// Powers up a 16x2 HD44780, then writes a snapshot of the 32-byte ASCII frame on each UpdateLCD.
// Define LCD_CLEAR_ON_UPDATE_EN to prefix every frame with a clear command.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYCLES  = 16,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000,
  parameter int unsigned PWR_WAIT   = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ASCII [0:31],
  input  logic       UpdateLCD,
  output logic       LCDBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

`ifdef LCD_CLEAR_ON_UPDATE_EN
  localparam logic [5:0] FRAME_OFS = 6'd1;
`else
  localparam logic [5:0] FRAME_OFS = 6'd0;
`endif
  localparam logic [5:0] FRAME_LAST = 6'd33 + FRAME_OFS;

  lcd_state_t  r_state;
  logic [31:0] r_cnt;
  logic [5:0]  r_idx;
  logic        r_pend;
  logic        r_busy;
  logic [7:0]  r_buf [0:31];

  logic        w_done;
  logic        w_start;
  logic        w_rs;
  logic [7:0]  w_data;
  logic [5:0]  w_sel;
  logic [5:0]  w_j;
  logic [4:0]  w_b1;
  logic [4:0]  w_b2;

  // w_sel is the index of the byte being launched by w_start this cycle.
  always_comb begin
    w_start = 1'b0;
    w_sel   = r_idx + 6'd1;
    case (r_state)
      ST_PWR: begin
        w_start = (r_cnt == PWR_WAIT - 1);
        w_sel   = 6'd0;
      end
      ST_INIT:  w_start = w_done && (r_idx != 6'd3);
      ST_IDLE: begin
        w_start = UpdateLCD || r_pend;
        w_sel   = 6'd0;
      end
      default:  w_start = w_done && (r_idx != FRAME_LAST);
    endcase
  end

  assign w_j  = w_sel - FRAME_OFS;
  assign w_b1 = 5'(w_j - 6'd1);
  assign w_b2 = 5'(w_j - 6'd2);

  always_comb begin
    w_rs   = 1'b0;
    w_data = LCD_LINE1;
    if (r_state == ST_PWR || r_state == ST_INIT) begin
      w_data = init_cmd(w_sel[1:0]);
    end else if ((FRAME_OFS != 6'd0) && (w_sel == 6'd0)) begin
      w_data = LCD_CLEAR;
    end else if (w_j == 6'd0) begin
      w_data = LCD_LINE1;
    end else if (w_j <= 6'd16) begin
      w_rs   = 1'b1;
      w_data = r_buf[w_b1];
    end else if (w_j == 6'd17) begin
      w_data = LCD_LINE2;
    end else begin
      w_rs   = 1'b1;
      w_data = r_buf[w_b2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PWR;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_PWR: begin
          r_pend <= r_pend | UpdateLCD;
          if (w_start) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_INIT, ST_FRAME: begin
          r_pend <= r_pend | UpdateLCD;
          if (w_done) begin
            if (w_start) begin
              r_idx <= r_idx + 6'd1;
            end else begin
              // Keep busy high through the one IDLE cycle if another frame is queued.
              r_state <= ST_IDLE;
              r_busy  <= r_pend | UpdateLCD;
            end
          end
        end
        default: begin
          r_busy <= w_start;
          if (w_start) begin
            r_state <= ST_FRAME;
            r_idx   <= '0;
            r_pend  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_start && (r_state == ST_IDLE)) begin
      r_buf <= ASCII;
    end
  end

  lcd_xfer #(
    .EN_CYCLES (EN_CYCLES),
    .CMD_WAIT  (CMD_WAIT),
    .CLEAR_WAIT(CLEAR_WAIT)
  ) u_xfer (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_start),
    .i_rs   (w_rs),
    .i_data (w_data),
    .o_done (w_done),
    .o_rs   (LCD_RS),
    .o_data (LCD_DATA),
    .o_en   (LCD_EN)
  );

  assign LCDBusy  = r_busy;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with shortened timing (T_CMD=16, T_CLR=26).
module tb_lcd_driver;

  localparam int INIT_LAT = 124;
`ifdef LCD_CLEAR_ON_UPDATE_EN
  localparam int FRAME_DUR = 570;
`else
  localparam int FRAME_DUR = 544;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ascii [0:31];
  logic       UpdateLCD;
  logic       LCDBusy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

  lcd_driver #(
    .EN_CYCLES (4),
    .CMD_WAIT  (10),
    .CLEAR_WAIT(20),
    .PWR_WAIT  (50)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ASCII    (ascii),
    .UpdateLCD(UpdateLCD),
    .LCDBusy  (LCDBusy),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON)
  );

  always #5 clk = ~clk;

  typedef struct {
    string l1;
    string l2;
    bit    scramble;
    int    exp_dur;
  } frame_vec_t;

  frame_vec_t vecs [3];
  logic [8:0] cap_q [$];
  logic [8:0] exp_q [$];
  int         wid_q [$];
  int         tests = 0;
  int         fails = 0;
  logic       prev_en = 1'b0;
  int         wcnt = 0;

  // Bus monitor: latch {RS,DATA} at each EN rise, record each EN high width.
  always @(negedge clk) begin
    if (LCD_EN && !prev_en) cap_q.push_back({LCD_RS, LCD_DATA});
    if (LCD_EN) wcnt++;
    else if (prev_en) begin
      wid_q.push_back(wcnt);
      wcnt = 0;
    end
    prev_en = LCD_EN;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ascii(input string l1, input string l2);
    for (int i = 0; i < 16; i++) begin
      ascii[i]      = l1[i];
      ascii[16 + i] = l2[i];
    end
  endtask

  task automatic add_exp(input string l1, input string l2);
`ifdef LCD_CLEAR_ON_UPDATE_EN
    exp_q.push_back({1'b0, 8'h01});
`endif
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
  endtask

  task automatic add_init_exp();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
  endtask

  task automatic cmp_widths(input string tag);
    for (int i = 0; i < wid_q.size(); i++)
      check($sformatf("%s_en_width%0d", tag, i), wid_q[i], 4);
  endtask

  task automatic count_to_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (LCDBusy && n < 5000);
  endtask

  task automatic trigger_and_measure(input bit scramble, output int dur);
    @(negedge clk); UpdateLCD = 1'b1;
    @(negedge clk); UpdateLCD = 1'b0;
    if (scramble) for (int i = 0; i < 32; i++) ascii[i] = 8'h58;
    dur = 0;
    while (LCDBusy && dur < 5000) begin
      dur++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int dur;

    vecs[0].l1 = "P1:0 P2:0 LVL:0 "; vecs[0].l2 = "HUMAN  VS  AI   ";
    vecs[0].scramble = 1'b0;         vecs[0].exp_dur = FRAME_DUR;
    vecs[1].l1 = "P1:0 P2:0 LVL:0 "; vecs[1].l2 = "HUMAN  VS  AI   ";
    vecs[1].scramble = 1'b1;         vecs[1].exp_dur = FRAME_DUR;
    vecs[2].l1 = "P1:9 P2:3 LVL:2 "; vecs[2].l2 = "GAME OVER  #@!~ ";
    vecs[2].scramble = 1'b0;         vecs[2].exp_dur = FRAME_DUR;

    reset = 1'b1;
    UpdateLCD = 1'b0;
    for (int i = 0; i < 32; i++) ascii[i] = 8'h20;
    repeat (3) @(negedge clk);
    check("rst_busy", LCDBusy, 1);
    check("rst_data", LCD_DATA, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_en", LCD_EN, 0);
    check("rst_on", LCD_ON, 1);
    check("rst_blon", LCD_BLON, 1);

    // Power-up and init sequence.
    reset = 1'b0;
    cap_q.delete(); wid_q.delete(); exp_q.delete();
    count_to_idle(n);
    check("init_busy_fall", n, INIT_LAT);
    add_init_exp();
    cmp_bytes("init");
    check("init_en_pulses", wid_q.size(), 4);
    cmp_widths("init");
    repeat (5) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      set_ascii(vecs[k].l1, vecs[k].l2);
      exp_q.delete(); add_exp(vecs[k].l1, vecs[k].l2);
      cap_q.delete(); wid_q.delete();
      trigger_and_measure(vecs[k].scramble, dur);
      check($sformatf("vec%0d_busy_cycles", k), dur, vecs[k].exp_dur);
      cmp_bytes($sformatf("vec%0d", k));
      if (k == 0) cmp_widths("vec0");
      repeat (5) @(negedge clk);
    end

    // Three triggers during a frame coalesce into one follow-up frame.
    set_ascii("AAAA BBBB CCCC D", "0123456789abcdef");
    exp_q.delete();
    add_exp("AAAA BBBB CCCC D", "0123456789abcdef");
    add_exp("zyxw vuts rqpo n", "LIVES 3  HI 0042");
    cap_q.delete(); wid_q.delete();
    @(negedge clk); UpdateLCD = 1'b1;
    @(negedge clk); UpdateLCD = 1'b0;
    dur = 0;
    while (LCDBusy && dur < 5000) begin
      dur++;
      if (dur == 10) set_ascii("zyxw vuts rqpo n", "LIVES 3  HI 0042");
      UpdateLCD = (dur == 50 || dur == 200 || dur == 400);
      @(negedge clk);
    end
    UpdateLCD = 1'b0;
    check("pend_busy_cycles", dur, 2 * FRAME_DUR + 1);
    cmp_bytes("pend");
    repeat (100) @(negedge clk);
    check("pend_no_third_frame", cap_q.size(), exp_q.size());
    check("pend_idle_after", LCDBusy, 0);

    // Reset asserted for one clock while EN is high mid-frame.
    cap_q.delete();
    @(negedge clk); UpdateLCD = 1'b1;
    @(negedge clk); UpdateLCD = 1'b0;
    n = 0;
    while (!(LCD_EN && cap_q.size() >= 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_en_before", LCD_EN, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_en_after", LCD_EN, 0);
    check("midrst_busy_after", LCDBusy, 1);
    check("midrst_data_after", LCD_DATA, 0);
    check("midrst_rs_after", LCD_RS, 0);
    reset = 1'b0;
    @(posedge clk);
    cap_q.delete(); wid_q.delete(); exp_q.delete();
    count_to_idle(n);
    check("midrst_busy_fall", n, INIT_LAT);
    add_init_exp();
    cmp_bytes("midrst_init");
    cmp_widths("midrst_init");
    repeat (50) @(negedge clk);
    check("midrst_no_frame", cap_q.size(), 4);
    check("midrst_idle", LCDBusy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
